// File: rtl/param_counter.sv
// param_counter: prescaled up/down counter with modulus, clear, load, wrap/saturate and tc pulse.
// Compare-match flag cmp_hit is compiled in only when PARAM_COUNTER_CMP_EN is defined.
module param_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_hit
);

    localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             step;

    assign step = en && (pre == PRE_LAST);

    always_comb begin
        count_nxt = count;
        pre_nxt   = pre;
        tc_nxt    = 1'b0;
        if (clr) begin
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (load) begin
            // widened compare keeps the clamp well-formed when MAX is all ones
            count_nxt = ({1'b0, load_val} > MAX_X) ? MAX_V : load_val;
            pre_nxt   = '0;
        end else if (step) begin
            pre_nxt = '0;
            if (up) begin
                if (count == MAX_V) begin
                    if (!sat) begin
                        count_nxt = '0;
                        tc_nxt    = 1'b1;
                    end
                end else begin
                    count_nxt = count + WIDTH'(1);
                    tc_nxt    = sat && (count_nxt == MAX_V);
                end
            end else begin
                if (count == '0) begin
                    if (!sat) begin
                        count_nxt = MAX_V;
                        tc_nxt    = 1'b1;
                    end
                end else begin
                    count_nxt = count - WIDTH'(1);
                    tc_nxt    = sat && (count_nxt == '0);
                end
            end
        end else if (en) begin
            pre_nxt = pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            pre   <= '0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            pre   <= pre_nxt;
        end
    end

`ifdef PARAM_COUNTER_CMP_EN
    // compared against the next count so the flag lines up with count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_hit <= 1'b0;
        end else begin
            cmp_hit <= (count_nxt == cmp_val);
        end
    end
`else
    logic [WIDTH-1:0] cmp_val_unused;
    assign cmp_val_unused = cmp_val;
    assign cmp_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: scoreboard bench for param_counter; instance a is MAX=9/PRESCALE=1,
// instance b is WIDTH=4/PRESCALE=3. Expected cmp_hit follows PARAM_COUNTER_CMP_EN.
module tb_param_counter;

`ifdef PARAM_COUNTER_CMP_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    typedef struct {
        string      name;
        bit         isb;
        logic [3:0] c;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, load, up, sat, en_b;
    logic [3:0] load_val, cmp_val;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, hit_a, hit_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .up(up), .sat(sat), .cmp_val(cmp_val), .count(count_a), .tc(tc_a), .cmp_hit(hit_a)
    );

    param_counter #(.WIDTH(4), .PRESCALE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .up(1'b1), .sat(1'b0), .cmp_val(cmp_val), .count(count_b), .tc(tc_b), .cmp_hit(hit_b)
    );

    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic push(input string n, input bit isb, input logic [3:0] c, input logic t);
        exp_t e;
        e.name = n; e.isb = isb; e.c = c; e.t = t;
        q.push_back(e);
    endtask

    // one edge on instance a; expectation is for the state after that edge
    task automatic cyca(input string n, input logic e_, input logic c_, input logic l_,
                        input logic [3:0] lv, input logic u_, input logic s_,
                        input logic [3:0] ec, input logic et);
        @(negedge clk); #1;
        en = e_; clr = c_; load = l_; load_val = lv; up = u_; sat = s_; en_b = 1'b0;
        push(n, 1'b0, ec, et);
    endtask

    task automatic cycb(input string n, input logic e_, input logic [3:0] ec, input logic et);
        @(negedge clk); #1;
        en = 1'b0; clr = 1'b0; load = 1'b0; en_b = e_;
        push(n, 1'b1, ec, et);
    endtask

    // monitor: compares the head of the scoreboard at every falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.isb) begin
                    chk({e.name, "_count"}, count_b, e.c);
                    chk({e.name, "_tc"}, {3'b0, tc_b}, {3'b0, e.t});
                    chk({e.name, "_hit"}, {3'b0, hit_b}, {3'b0, CMP_ON && (e.c == 4'd4)});
                end else begin
                    chk({e.name, "_count"}, count_a, e.c);
                    chk({e.name, "_tc"}, {3'b0, tc_a}, {3'b0, e.t});
                    chk({e.name, "_hit"}, {3'b0, hit_a}, {3'b0, CMP_ON && (e.c == 4'd4)});
                end
            end
        end
    end

    initial begin
        logic [3:0] wrap_c [12];
        logic [3:0] pre_c  [9];
        wrap_c = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        pre_c  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1; sat = 1'b0;
        en_b = 1'b0; load_val = 4'd0; cmp_val = 4'd4;
        #12;
        chk("rst_count_a", count_a, 4'd0);
        chk("rst_tc_a", {3'b0, tc_a}, 4'd0);
        chk("rst_hit_a", {3'b0, hit_a}, 4'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            cyca("wrap", 1, 0, 0, 4'd0, 1, 0, wrap_c[i], wrap_c[i] == 4'd0);

        cyca("load2", 1, 0, 1, 4'd2, 1, 0, 4'd2, 0);
        cyca("satdn", 1, 0, 0, 4'd0, 0, 1, 4'd1, 0);
        cyca("satdn", 1, 0, 0, 4'd0, 0, 1, 4'd0, 1);
        cyca("satdn_hold", 1, 0, 0, 4'd0, 0, 1, 4'd0, 0);
        cyca("satdn_hold", 1, 0, 0, 4'd0, 0, 1, 4'd0, 0);

        cyca("load8", 1, 0, 1, 4'd8, 1, 1, 4'd8, 0);
        cyca("satup", 1, 0, 0, 4'd0, 1, 1, 4'd9, 1);
        cyca("satup_hold", 1, 0, 0, 4'd0, 1, 1, 4'd9, 0);

        cyca("load0", 1, 0, 1, 4'd0, 0, 0, 4'd0, 0);
        cyca("wrapdn", 1, 0, 0, 4'd0, 0, 0, 4'd9, 1);
        cyca("dn", 1, 0, 0, 4'd0, 0, 0, 4'd8, 0);

        cyca("clr_load", 1, 1, 1, 4'd5, 1, 0, 4'd0, 0);
        cyca("load_clamp", 0, 0, 1, 4'd15, 1, 0, 4'd9, 0);
        cyca("en_low", 0, 0, 0, 4'd0, 1, 0, 4'd9, 0);
        cyca("wrap_max", 1, 0, 0, 4'd0, 1, 0, 4'd0, 1);
        cyca("clr_en_low", 0, 1, 0, 4'd0, 1, 0, 4'd0, 0);
        for (int i = 1; i <= 7; i++)
            cyca("to7", 1, 0, 0, 4'd0, 1, 0, 4'(i), 0);

        for (int i = 0; i < 9; i++)
            cycb("pre", 1, pre_c[i], 0);
        cycb("pre_mid", 1, 4'd3, 0);
        cycb("pre_frz", 0, 4'd3, 0);
        cycb("pre_frz", 0, 4'd3, 0);
        cycb("pre_resume", 1, 4'd3, 0);
        cycb("pre_resume", 1, 4'd4, 0);
        cycb("pre_mid2", 1, 4'd4, 0);

        @(negedge clk);
        en_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count_a", count_a, 4'd0);
        chk("arst_tc_a", {3'b0, tc_a}, 4'd0);
        chk("arst_count_b", count_b, 4'd0);
        chk("arst_hit_b", {3'b0, hit_b}, 4'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        cyca("post_rst", 1, 0, 0, 4'd0, 1, 0, 4'd1, 0);
        cyca("post_rst", 1, 0, 0, 4'd0, 1, 0, 4'd2, 0);
        cyca("post_rst", 1, 0, 0, 4'd0, 1, 0, 4'd3, 0);
        cycb("post_rst_b", 1, 4'd0, 0);
        cycb("post_rst_b", 1, 4'd0, 0);
        cycb("post_rst_b", 1, 4'd1, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_counter.md
# param_counter

Parametrised, prescaled up/down counter. It replaces the fixed 4-bit free-running counter used in bring-up benches and serves as the general timebase and event counter for the design. Adds modulus, direction, load, clear, wrap or saturate mode, and a terminal-count pulse. An optional compare-match flag is compiled in by macro.

## Interface
- WIDTH, default 4: counter width in bits (≥1).
- MAX, default 2**WIDTH-1: terminal value; count range is 0..MAX; requires 1 ≤ MAX ≤ 2**WIDTH-1.
- PRESCALE, default 1: enabled cycles per count step (≥1); 1 means step every enabled cycle.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; low freezes count and prescaler.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value.
- up  input  1  direction: 1 counts up, 0 counts down.
- sat  input  1  mode: 1 saturates at the limits, 0 wraps.
- cmp_val  input  WIDTH  compare value; ignored without the macro.
- count  output  WIDTH  current count.
- tc  output  1  terminal-count pulse.
- cmp_hit  output  1  compare-match flag; tied 0 without the macro.

## Operation
- Reset (rst_n low, async): count=0, tc=0, cmp_hit=0, prescaler=0. Outputs are valid the first edge after release.
- Per-edge priority: clr > load > step > hold.
- clr: count←0, prescaler←0, tc←0. Applies regardless of en.
- load: count←min(load_val, MAX), prescaler←0, tc←0. Applies regardless of en.
- Prescaler: internal counter 0..PRESCALE-1, advanced only when en=1. A step occurs on an enabled edge with prescaler=PRESCALE-1, and the prescaler then returns to 0. With PRESCALE=1, every enabled edge is a step.
- Step, up=1:
  - count<MAX: count+1.
  - count=MAX, sat=0: wrap to 0.
  - count=MAX, sat=1: hold MAX.
- Step, up=0:
  - count>0: count-1.
  - count=0, sat=0: wrap to MAX.
  - count=0, sat=1: hold 0.
- tc is registered and is 1 for exactly one cycle, aligned with the new count, after a step that:
  - wraps (MAX→0 up, 0→MAX down), or
  - with sat=1, moves count onto the limit (MAX up, 0 down) from another value.
  - A step that holds at a limit does not assert tc.
- tc is 0 on every non-step edge.
- up and sat are sampled only on step edges. Changing them mid-prescale takes effect at the next step.
- Arithmetic is unsigned, WIDTH bits. No intermediate value exceeds MAX.

## Timing
- All outputs are registered. Latency from input to count/tc/cmp_hit is one clock edge.
- clr/load seen at edge N: count shows the new value after edge N, and the next possible step is edge N+PRESCALE (with en held high).
- en deasserted: count, tc (forced 0) and prescaler hold. On reassertion, the prescaler resumes from its held value.
- Simultaneous clr and load: clr wins. Simultaneous load and step: load wins and the step is discarded.
- Reset asserted mid-prescale: everything returns to its reset value immediately, without waiting for clk.

## Configuration
- Macro PARAM_COUNTER_CMP_EN.
- Defined: cmp_hit is registered and equals (next count == cmp_val), so it is aligned with count. It is asserted for as long as count==cmp_val, including after clr or load. It is 0 during reset.
- Undefined: no compare logic; cmp_hit is constant 0; cmp_val is unused. The port list is unchanged.

## Test plan
- Wrap up: WIDTH=4, MAX=9, PRESCALE=1, up=1, sat=0, en=1 for 12 edges → count 1..9,0,1,2; tc=1 only in the cycle count=0.
- Saturate down: load_val=2, then up=0, sat=1, en=1 for 4 edges → count 1,0,0,0; tc=1 once at the first 0.
- Prescale: PRESCALE=3, en=1 for 9 edges from 0 → count steps only on edges 3, 6 and 9 (1, 2, 3). Drop en for 2 edges at prescaler=1 → count and prescaler freeze.
- Priority: clr=1, load=1, load_val=5 on a step edge → count=0, tc=0. Then load only with load_val=15, MAX=9 → count=9.
- Async reset: assert rst_n=0 between edges while count=7 → count=0 and tc=0 before the next edge. Release → counting restarts from 0 with prescaler=0.
- Compare (PARAM_COUNTER_CMP_EN defined): cmp_val=4, count up from 0 → cmp_hit=1 exactly while count=4. Without the macro, cmp_hit stays 0 throughout.
